stream_maxval_tracker: RTL and testbench

//  Streaming counterpart to the min-value function: finds the unsigned maximum of a frame of

---
 rtl/maxval_pkg.sv | 13 +
 rtl/maxval_cmp.sv | 12 +
 rtl/stream_maxval_tracker.sv | 115 +++++++++++
 tb/tb_stream_maxval_tracker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/maxval_pkg.sv
// Shared state encoding and default widths for the streaming max tracker.
package maxval_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned IDX_W_DEF  = 8;

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_ACC   = 2'd1,
        S_OUT   = 2'd2
    } state_e;

endpackage

// File: rtl/maxval_cmp.sv
// Combinational unsigned greater-than; kept separate so a signed or min variant can drop in.
module maxval_cmp #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);

    assign gt = (a > b);

endmodule

// File: rtl/stream_maxval_tracker.sv
// Tracks the unsigned maximum, its first index and the length of a streamed frame,
// and presents the result on a registered valid/ready port.
module stream_maxval_tracker
    import maxval_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W-1:0]  out_len,
    output logic              out_ovf
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    len_q, len_d;
    logic                ovf_q, ovf_d;
    logic                accept;
    logic                gt;
    logic                cnt_full;

    maxval_cmp #(.W(DATA_W)) u_cmp (
        .a  (in_data),
        .b  (max_q),
        .gt (gt)
    );

    assign in_ready  = (state_q != S_OUT);
    assign out_valid = (state_q == S_OUT);
    assign accept    = in_valid && in_ready;
    assign cnt_full  = (cnt_q == '1);

    // max/idx/len/ovf double as the result registers: nothing updates them in S_OUT.
    assign out_max = max_q;
    assign out_idx = idx_q;
    assign out_len = len_q;
    assign out_ovf = ovf_q;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_FIRST: begin
                if (accept) begin
                    max_d = in_data;
                    idx_d = '0;
                    cnt_d = IDX_W'(1);
                    if (in_last) begin
                        len_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = S_OUT;
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (accept) begin
                    if (gt) begin
                        max_d = in_data;
                        idx_d = cnt_q;
                    end
                    cnt_d = cnt_q + 1'b1;
                    // Pre-increment count equals samples-1, i.e. the reported length.
                    if (in_last || cnt_full) begin
                        len_d   = cnt_q;
                        ovf_d   = !in_last;
                        cnt_d   = '0;
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_FIRST;
                end
            end
            default: state_d = S_FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FIRST;
            max_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_stream_maxval_tracker.sv
// Self-checking bench: frame table plus hand sequences, results checked via a scoreboard.
module tb_stream_maxval_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_max;
    logic [7:0] out_idx;
    logic [7:0] out_len;
    logic       out_ovf;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct packed {
        logic [7:0] mx;
        logic [7:0] ix;
        logic [7:0] ln;
        logic       ov;
    } exp_t;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  n;
        logic        gaps;
        logic [7:0]  emax;
        logic [7:0]  eidx;
        logic [7:0]  elen;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];

    always #5 clk = ~clk;

    stream_maxval_tracker #(.DATA_W(8), .IDX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_len   (out_len),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] d, input int n, input bit g,
                                input int mx, input int ix, input int ln);
        vec_t v;
        v.d    = d;
        v.n    = 8'(n);
        v.gaps = g;
        v.emax = 8'(mx);
        v.eidx = 8'(ix);
        v.elen = 8'(ln);
        return v;
    endfunction

    function automatic exp_t mke(input int mx, input int ix, input int ln, input bit ov);
        exp_t e;
        e.mx = 8'(mx);
        e.ix = 8'(ix);
        e.ln = 8'(ln);
        e.ov = ov;
        return e;
    endfunction

    // Results leave the DUT on a handshake; seen at negedge, taken at the next posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got max=%0d with empty scoreboard", out_max);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_max", out_max, e.mx);
                chk("sb_idx", out_idx, e.ix);
                chk("sb_len", out_len, e.ln);
                chk("sb_ovf", out_ovf, e.ov);
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic last, input bit gap);
        int unsigned b;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        b = 0;
        while (!in_ready && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_timeout: got in_ready=0 required 1 within 100 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int unsigned b;
        b = 0;
        while (sb.size() != 0 && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        tbl[0] = mk(32'h2D0C2D17, 4, 1'b0, 45, 1, 3);
        tbl[1] = mk(32'h00000064, 1, 1'b0, 100, 0, 0);
        tbl[2] = mk(32'h00000000, 3, 1'b1, 0, 0, 2);
        tbl[3] = mk(32'h00000737, 2, 1'b0, 55, 0, 1);
        tbl[4] = mk(32'h04030201, 4, 1'b1, 4, 3, 3);
        tbl[5] = mk(32'h00FFFFC8, 4, 1'b0, 255, 1, 3);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_max", out_max, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_len", out_len, 0);
        chk("rst_out_ovf", out_ovf, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;

        for (int i = 0; i < 6; i++) begin
            sb.push_back(mke(int'(tbl[i].emax), int'(tbl[i].eidx), int'(tbl[i].elen), 1'b0));
            for (int k = 0; k < int'(tbl[i].n); k++)
                send_beat(tbl[i].d[8*k +: 8], k == int'(tbl[i].n) - 1, tbl[i].gaps);
            chk("latency_out_valid", out_valid, 1);
            if (tbl[i].n == 1)
                chk("in_ready_low_in_out", in_ready, 0);
            drain();
        end

        // Back-pressure: result must hold and input must stay blocked.
        out_ready = 1'b0;
        sb.push_back(mke(77, 0, 1, 1'b0));
        send_beat(8'd77, 1'b0, 1'b0);
        send_beat(8'd3, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_max", out_max, 77);
            chk("stall_out_len", out_len, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();
        sb.push_back(mke(55, 0, 1, 1'b0));
        send_beat(8'd55, 1'b0, 1'b0);
        send_beat(8'd7, 1'b1, 1'b0);
        drain();

        // Length overflow force-closes the frame without in_last.
        sb.push_back(mke(255, 255, 255, 1'b1));
        for (int v = 0; v < 256; v++)
            send_beat(8'(v), 1'b0, 1'b0);
        chk("ovf_out_valid", out_valid, 1);
        drain();
        sb.push_back(mke(5, 0, 0, 1'b0));
        send_beat(8'd5, 1'b1, 1'b0);
        drain();

        // Mid-frame reset drops the partial frame.
        send_beat(8'd9, 1'b0, 1'b0);
        send_beat(8'd200, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("after_rst_out_valid", out_valid, 0);
        chk("after_rst_in_ready", in_ready, 1);
        chk("after_rst_out_max", out_max, 0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("after_rst_idle_valid", out_valid, 0);
        sb.push_back(mke(3, 0, 0, 1'b0));
        send_beat(8'd3, 1'b1, 1'b0);
        drain();

        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
